// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the neuron training controller.
package nn_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FWD,
      CHECK,
      BP,
      CLEAR,
      DONE
   } state_e;

   localparam int ABS_W           = 8;
   localparam int DEFAULT_TOL     = 2;
   localparam int DEFAULT_TIMEOUT = 31;

   function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                 input logic [ABS_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/train_sequencer_if.sv
// Handshake between the training sequencer and the neuron/backprop datapath.
interface train_sequencer_if #(
   parameter int N_BP = 4
);
   logic [3:0]      target;
   logic [18:0]     final_val;
   logic            fwd_done;
   logic [N_BP-1:0] bp_done;
   logic            f0_pass;
   logic            f1_pass;
   logic            b_pass;
   logic            zero_loss;
   logic            zero_final;
   logic            zero_weight_update;

   modport master (
      input  target, final_val, fwd_done, bp_done,
      output f0_pass, f1_pass, b_pass, zero_loss, zero_final, zero_weight_update
   );

   modport slave (
      output target, final_val, fwd_done, bp_done,
      input  f0_pass, f1_pass, b_pass, zero_loss, zero_final, zero_weight_update
   );
endinterface

// File: rtl/phase_timer.sv
// Saturating per-phase cycle counter; expired_o flags the TIMEOUT_CYC-th enabled cycle.
module phase_timer
   import nn_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int             CW   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0]  MAXV = CW'(TIMEOUT_CYC);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != MAXV)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q holds the cycles already spent, so the current cycle is count_q+1.
   assign expired_o = (count_q >= LAST);

endmodule

// File: rtl/train_sequencer.sv
// Training controller: sequences each sample through FWD/CHECK/BP/CLEAR and
// tracks samples, epochs, consecutive hits and the stop reason.
module train_sequencer
   import nn_ctrl_pkg::*;
#(
   parameter int N_SAMPLES   = 4,
   parameter int MAX_EPOCHS  = 8,
   parameter int EPOCH_W     = 4,
   parameter int TOL         = DEFAULT_TOL,
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT,
   parameter int N_BP        = 4,
   localparam int SW         = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               start_i,
   input  logic               abort_i,
   train_sequencer_if.master  dp,
   output logic [SW-1:0]      sample_idx_o,
   output logic [EPOCH_W-1:0] epoch_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               converged_o,
   output logic               timeout_o
);
   localparam int                 HW       = $clog2(N_SAMPLES + 1);
   localparam logic [HW-1:0]      HITS_ALL = HW'(N_SAMPLES);
   localparam logic [SW-1:0]      LAST_S   = SW'(N_SAMPLES - 1);
   localparam logic [EPOCH_W-1:0] MAX_E    = EPOCH_W'(MAX_EPOCHS);
   localparam logic [ABS_W-1:0]   TOL_V    = ABS_W'(TOL);

   state_e             state_q, state_d;
   logic [SW-1:0]      sample_q, sample_d;
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic [HW-1:0]      hits_q, hits_d;
   logic [N_BP-1:0]    mask_q, mask_d;
   logic               first_q, first_d;
   logic               converged_q, converged_d;
   logic               timeout_q, timeout_d;
   logic               f0_q, f0_d, f1_q, f1_d, b_q, b_d, zero_q, zero_d;
   logic               busy_q, busy_d, done_q, done_d;

   logic [ABS_W-1:0]   err;
   logic [N_BP-1:0]    mask_all;
   logic               in_phase, timer_clr, timer_en, timer_expired;
   logic               unused_final;

   assign unused_final = ^dp.final_val[18:ABS_W];

   phase_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (timer_clr),
      .en_i      (timer_en),
      .expired_o (timer_expired)
   );

   always_comb begin
      // NOTE: every _d takes its held value first so no branch can infer a latch.
      state_d     = state_q;
      sample_d    = sample_q;
      epoch_d     = epoch_q;
      hits_d      = hits_q;
      mask_d      = mask_q;
      first_d     = first_q;
      converged_d = converged_q;
      timeout_d   = timeout_q;
      zero_d      = 1'b0;
      timer_clr   = 1'b0;
      timer_en    = 1'b0;
      err         = abs_diff(dp.final_val[ABS_W-1:0], ABS_W'(dp.target));
      mask_all    = mask_q | dp.bp_done;
      in_phase    = (state_q == FWD) || (state_q == BP);

      if (abort_i) begin
         state_d     = IDLE;
         sample_d    = '0;
         epoch_d     = '0;
         hits_d      = '0;
         mask_d      = '0;
         first_d     = 1'b0;
         converged_d = 1'b0;
         timeout_d   = 1'b0;
         timer_clr   = 1'b1;
      end else if (en_i) begin
         timer_en  = in_phase;
         timer_clr = !in_phase;
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  state_d     = FWD;
                  sample_d    = '0;
                  epoch_d     = '0;
                  hits_d      = '0;
                  first_d     = 1'b1;
                  converged_d = 1'b0;
                  timeout_d   = 1'b0;
               end
            end
            FWD: begin
               if (dp.fwd_done) begin
                  state_d = CHECK;
               end else if (timer_expired) begin
                  state_d   = DONE;
                  timeout_d = 1'b1;
               end
            end
            CHECK: begin
               hits_d = (err <= TOL_V) ? hits_q + 1'b1 : '0;
               if (hits_d == HITS_ALL) begin
                  state_d     = DONE;
                  converged_d = 1'b1;
               end else begin
                  state_d = BP;
               end
            end
            BP: begin
               // A unit finishing in the same cycle as the last straggler still counts.
               if (&mask_all) begin
                  state_d = CLEAR;
                  mask_d  = '0;
               end else if (timer_expired) begin
                  state_d   = DONE;
                  timeout_d = 1'b1;
                  mask_d    = '0;
               end else begin
                  mask_d = mask_all;
               end
            end
            CLEAR: begin
               first_d = 1'b0;
               state_d = FWD;
               if (sample_q == LAST_S) begin
                  sample_d = '0;
                  epoch_d  = epoch_q + 1'b1;
                  if (epoch_d == MAX_E) begin
                     state_d = DONE;
                  end
               end else begin
                  sample_d = sample_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
         zero_d = (state_d == CLEAR);
      end

      // Moore outputs are decoded from the next state so they line up with it.
      f0_d   = (state_d == FWD) && first_d;
      f1_d   = (state_d == FWD) && !first_d;
      b_d    = (state_d == BP);
      busy_d = (state_d != IDLE) && (state_d != DONE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         sample_q    <= '0;
         epoch_q     <= '0;
         hits_q      <= '0;
         mask_q      <= '0;
         first_q     <= 1'b0;
         converged_q <= 1'b0;
         timeout_q   <= 1'b0;
         f0_q        <= 1'b0;
         f1_q        <= 1'b0;
         b_q         <= 1'b0;
         zero_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking here so every flop samples the pre-edge values.
         state_q     <= state_d;
         sample_q    <= sample_d;
         epoch_q     <= epoch_d;
         hits_q      <= hits_d;
         mask_q      <= mask_d;
         first_q     <= first_d;
         converged_q <= converged_d;
         timeout_q   <= timeout_d;
         f0_q        <= f0_d;
         f1_q        <= f1_d;
         b_q         <= b_d;
         zero_q      <= zero_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign dp.f0_pass            = f0_q;
   assign dp.f1_pass            = f1_q;
   assign dp.b_pass             = b_q;
   assign dp.zero_loss          = zero_q;
   assign dp.zero_final         = zero_q;
   assign dp.zero_weight_update = zero_q;
   assign sample_idx_o          = sample_q;
   assign epoch_o               = epoch_q;
   assign busy_o                = busy_q;
   assign done_o                = done_q;
   assign converged_o           = converged_q;
   assign timeout_o             = timeout_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Scoreboard bench for train_sequencer: directed runs push expected phase
// events; a negedge monitor pops and compares them as the DUT produces them.
module tb_train_sequencer;

   typedef enum int {EV_NONE, EV_F0, EV_F1, EV_ZERO, EV_DONE} ev_e;
   typedef struct {
      ev_e kind;
      int  sample;
      int  epoch;
      bit  conv;
      bit  tmo;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n, en, start, abort;
   logic [1:0] sample_idx;
   logic [3:0] epoch;
   logic       busy, done, converged, timeout;

   int  checks = 0;
   int  errors = 0;
   ev_t exp_q[$];
   ev_t mon_ev;
   logic f0_p = 1'b0, f1_p = 1'b0, done_p = 1'b0;

   train_sequencer_if #(.N_BP(4)) dp ();

   train_sequencer dut (
      .clk_i        (clk),
      .rst_i        (rst_n),
      .en_i         (en),
      .start_i      (start),
      .abort_i      (abort),
      .dp           (dp),
      .sample_idx_o (sample_idx),
      .epoch_o      (epoch),
      .busy_o       (busy),
      .done_o       (done),
      .converged_o  (converged),
      .timeout_o    (timeout)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic void push(input ev_e k, input int s, input int e, input bit c, input bit t);
      ev_t x;
      x.kind = k; x.sample = s; x.epoch = e; x.conv = c; x.tmo = t;
      exp_q.push_back(x);
   endfunction

   task automatic got(input ev_t a);
      ev_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_event", a.kind, EV_NONE);
      end else begin
         e = exp_q.pop_front();
         check("ev_kind", a.kind, e.kind);
         check("ev_sample", a.sample, e.sample);
         check("ev_epoch", a.epoch, e.epoch);
         if (e.kind == EV_DONE) begin
            check("ev_converged", a.conv, e.conv);
            check("ev_timeout", a.tmo, e.tmo);
         end
      end
   endtask

   // Monitor: one event per rising phase enable, per clear pulse, per DONE entry.
   always @(negedge clk) begin
      mon_ev.sample = int'(sample_idx);
      mon_ev.epoch  = int'(epoch);
      mon_ev.conv   = converged;
      mon_ev.tmo    = timeout;
      if (dp.f0_pass && !f0_p) begin mon_ev.kind = EV_F0; got(mon_ev); end
      if (dp.f1_pass && !f1_p) begin mon_ev.kind = EV_F1; got(mon_ev); end
      if (dp.zero_loss || dp.zero_final || dp.zero_weight_update) begin
         check("zero_pulses_equal", {dp.zero_loss, dp.zero_final, dp.zero_weight_update}, 3'b111);
         mon_ev.kind = EV_ZERO;
         got(mon_ev);
      end
      if (done && !done_p) begin mon_ev.kind = EV_DONE; got(mon_ev); end
      f0_p   <= dp.f0_pass;
      f1_p   <= dp.f1_pass;
      done_p <= done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit cond(input int which);
      case (which)
         0:       return dp.f0_pass || dp.f1_pass;
         1:       return dp.b_pass;
         default: return done;
      endcase
   endfunction

   task automatic wait_for(input int which, input string nm);
      int n = 0;
      while (!cond(which) && n < 64) begin
         tick();
         n++;
      end
      check(nm, cond(which), 1);
   endtask

   task automatic do_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic fwd(input logic [3:0] tgt, input logic [18:0] fin);
      wait_for(0, "wait_fwd");
      dp.target = tgt; dp.final_val = fin; dp.fwd_done = 1'b1;
      tick();
      dp.fwd_done = 1'b0;
   endtask

   task automatic bp_all();
      wait_for(1, "wait_bp");
      dp.bp_done = 4'hF; tick(); dp.bp_done = 4'h0;
   endtask

   task automatic run_sample(input logic [3:0] tgt, input logic [18:0] fin);
      fwd(tgt, fin);
      bp_all();
   endtask

   task automatic all_zero(input string nm);
      check(nm, {dp.f0_pass, dp.f1_pass, dp.b_pass, dp.zero_loss, dp.zero_final,
                 dp.zero_weight_update, busy, done, converged, timeout, sample_idx, epoch}, 0);
   endtask

   logic [3:0]  hr_tgt [8] = '{4'd4, 4'd8, 4'd12, 4'd3, 4'd1, 4'd2, 4'd7, 4'd10};
   logic [18:0] hr_fin [8] = '{19'd6, 19'd8, 19'd10, 19'd0, 19'd3, 19'd0, 19'd7, 19'h4000C};

   initial begin
      rst_n = 1'b0; en = 1'b1; start = 1'b0; abort = 1'b0;
      dp.target = 4'd9; dp.final_val = '0; dp.fwd_done = 1'b0; dp.bp_done = '0;
      repeat (3) tick();
      all_zero("reset_state");
      rst_n = 1'b1;
      tick();

      // Reset while in BP, then restart.
      push(EV_F0, 0, 0, 0, 0);
      do_start();
      fwd(4'd9, 19'd0);
      wait_for(1, "wait_bp_for_reset");
      rst_n = 1'b0;
      #1;
      all_zero("reset_mid_bp");
      #2 rst_n = 1'b1;
      tick();

      // Nominal: never converges, stops at the epoch limit.
      push(EV_F0, 0, 0, 0, 0);
      do_start();
      check("restart_f0", dp.f0_pass, 1);
      for (int i = 0; i < 32; i++) begin
         push(EV_ZERO, i % 4, i / 4, 0, 0);
         if (i < 31) push(EV_F1, (i + 1) % 4, (i + 1) / 4, 0, 0);
         else        push(EV_DONE, 0, 8, 0, 0);
         run_sample(4'd9, 19'd0);
      end
      wait_for(2, "wait_done_nominal");
      check("nom_epoch", epoch, 8);
      check("nom_flags", {busy, converged, timeout, dp.f0_pass, dp.f1_pass, dp.b_pass}, 0);

      // Convergence: four hits at exactly |err| = TOL.
      push(EV_F0, 0, 0, 0, 0);
      do_start();
      push(EV_ZERO, 0, 0, 0, 0); push(EV_F1, 1, 0, 0, 0); run_sample(4'd5, 19'd7);
      push(EV_ZERO, 1, 0, 0, 0); push(EV_F1, 2, 0, 0, 0); run_sample(4'd9, 19'd7);
      push(EV_ZERO, 2, 0, 0, 0); push(EV_F1, 3, 0, 0, 0); run_sample(4'd0, 19'd2);
      push(EV_DONE, 3, 0, 1, 0);
      fwd(4'd15, 19'h7FF11);
      wait_for(2, "wait_done_conv");
      check("conv_result", {converged, timeout, epoch, sample_idx}, {1'b1, 1'b0, 4'd0, 2'd3});

      // A miss (err 3) resets the hit run; staggered bp_done on the first sample.
      push(EV_F0, 0, 0, 0, 0);
      do_start();
      push(EV_ZERO, 0, 0, 0, 0); push(EV_F1, 1, 0, 0, 0);
      fwd(hr_tgt[0], hr_fin[0]);
      wait_for(1, "wait_bp_stagger");
      dp.bp_done = 4'b0011; tick();
      dp.bp_done = 4'b0000; check("stagger_c2", dp.b_pass, 1); tick();
      dp.bp_done = 4'b0100; tick();
      dp.bp_done = 4'b0000; check("stagger_c4", {dp.b_pass, dp.zero_loss}, 2'b10); tick();
      dp.bp_done = 4'b1000; check("stagger_c5", dp.b_pass, 1); tick();
      dp.bp_done = 4'b0000;
      check("stagger_clear", {dp.b_pass, dp.zero_loss}, 2'b01);
      for (int k = 1; k < 7; k++) begin
         push(EV_ZERO, k % 4, k / 4, 0, 0);
         push(EV_F1, (k + 1) % 4, (k + 1) / 4, 0, 0);
         run_sample(hr_tgt[k], hr_fin[k]);
      end
      push(EV_DONE, 3, 1, 1, 0);
      fwd(hr_tgt[7], hr_fin[7]);
      wait_for(2, "wait_done_hits");
      check("hits_result", {converged, epoch, sample_idx}, {1'b1, 4'd1, 2'd3});

      // FWD timeout: no fwd_done at all.
      push(EV_F0, 0, 0, 0, 0);
      push(EV_DONE, 0, 0, 0, 1);
      do_start();
      repeat (30) tick();
      check("fwd_cycle31_alive", {dp.f0_pass, done}, 2'b10);
      tick();
      check("fwd_timeout", {done, timeout, dp.f0_pass, busy, converged}, 5'b11000);

      // fwd_done on the 31st cycle wins, then BP times out on a partial mask.
      push(EV_F0, 0, 0, 0, 0);
      push(EV_DONE, 0, 0, 0, 1);
      do_start();
      repeat (30) tick();
      dp.fwd_done = 1'b1; tick(); dp.fwd_done = 1'b0;
      check("done_on_last_cycle", {dp.f0_pass, busy, done, timeout}, 4'b0100);
      tick();
      check("bp_entered", dp.b_pass, 1);
      dp.bp_done = 4'b0111; tick(); dp.bp_done = 4'b0000;
      repeat (29) tick();
      check("bp_cycle31_alive", {dp.b_pass, done}, 2'b10);
      tick();
      check("bp_timeout", {done, timeout, dp.b_pass, dp.zero_loss}, 4'b1100);

      // Freeze in CLEAR, then ignored start and abort in FWD.
      push(EV_F0, 0, 0, 0, 0);
      push(EV_ZERO, 0, 0, 0, 0);
      push(EV_F1, 1, 0, 0, 0);
      do_start();
      fwd(4'd9, 19'd0);
      wait_for(1, "wait_bp_freeze");
      dp.bp_done = 4'hF; tick(); dp.bp_done = 4'h0;
      en = 1'b0;
      check("clear_pulse", dp.zero_loss, 1);
      for (int c = 0; c < 5; c++) begin
         tick();
         check("frozen_clear", {dp.zero_loss, dp.zero_final, dp.zero_weight_update,
                                dp.f1_pass, busy, sample_idx}, {5'b00001, 2'd0});
      end
      en = 1'b1;
      tick();
      check("after_unfreeze", {dp.f1_pass, sample_idx}, {1'b1, 2'd1});
      do_start();
      check("start_ignored", {dp.f0_pass, dp.f1_pass, sample_idx}, {2'b01, 2'd1});
      abort = 1'b1; tick(); abort = 1'b0;
      all_zero("after_abort");
      tick();
      check("stay_idle", busy, 0);

      repeat (2) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
